// File: rtl/pipe_lane_reg_pkg.sv
// Shared defines for the pipeline lane register: bus widths, control levels and the
// per-edge action encoding used by the top and the per-lane slot.
package pipe_lane_reg_pkg;

  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b1;
  localparam logic        Stop        = 1'b1;
  localparam logic        NoStop      = 1'b0;

  typedef logic [2:0] act_t;

  localparam act_t ACT_RESET   = 3'd0;
  localparam act_t ACT_FLUSH   = 3'd1;
  localparam act_t ACT_BUBBLE  = 3'd2;
  localparam act_t ACT_CAPTURE = 3'd3;
  localparam act_t ACT_HOLD    = 3'd4;

endpackage

// File: rtl/pipe_lane_reg_slot.sv
// One instruction slot (pc, inst, valid) of the inter-stage register; the action is
// decoded once in the top and shared by every lane.
module pipe_lane_slot
  import pipe_lane_reg_pkg::*;
#(
  parameter int PC_W   = InstAddrBus,
  parameter int INST_W = InstBus
) (
  input  logic              clk,
  input  act_t              act,
  input  logic              eff_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst
);

  // stage boundary: producing stage -> consuming stage
  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
        valid <= 1'b0;
        pc    <= '0;
        inst  <= '0;
      end
      ACT_CAPTURE: begin
        // a killed or empty lane is zeroed so downstream sees a clean nop
        valid <= eff_valid;
        pc    <= eff_valid ? in_pc   : '0;
        inst  <= eff_valid ? in_inst : '0;
      end
      default: begin
        valid <= valid;
        pc    <= pc;
        inst  <= inst;
      end
    endcase
  end

endmodule

// File: rtl/pipe_lane_reg.sv
// Multi-lane inter-stage pipeline register with flush, bubble insertion and per-lane kill.
// Optional PIPE_LANE_PERF_CNT_EN adds saturating bubble/hold/flush event counters.
module pipe_lane_reg
  import pipe_lane_reg_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int PC_W      = InstAddrBus,
  parameter int INST_W    = InstBus,
  parameter int STALL_W   = 6,
  parameter int STAGE     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [STALL_W-1:0]          stall,
  input  logic                        flush,
  input  logic [NUM_LANES-1:0]        in_valid,
  input  logic [NUM_LANES-1:0]        in_kill,
  input  logic [NUM_LANES*PC_W-1:0]   in_pc,
  input  logic [NUM_LANES*INST_W-1:0] in_inst,
  output logic [NUM_LANES-1:0]        out_valid,
  output logic [NUM_LANES*PC_W-1:0]   out_pc,
  output logic [NUM_LANES*INST_W-1:0] out_inst,
  output logic                        out_bubble
`ifdef PIPE_LANE_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_bubble_cnt,
  output logic [31:0]                 perf_hold_cnt,
  output logic [31:0]                 perf_flush_cnt
`endif
);

  logic                 s_me;
  logic                 s_nx;
  act_t                 act;
  logic [NUM_LANES-1:0] eff_valid;

  assign s_me      = stall[STAGE];
  assign s_nx      = stall[STAGE+1];
  assign eff_valid = in_valid & ~in_kill;

  always_comb begin
    act = ACT_HOLD;
    if (rst == RstEnable)
      act = ACT_RESET;
    else if (flush)
      act = ACT_FLUSH;
    else if (s_me == Stop && s_nx == NoStop)
      act = ACT_BUBBLE;
    else if (s_me == NoStop)
      act = ACT_CAPTURE;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pipe_lane_slot #(
      .PC_W  (PC_W),
      .INST_W(INST_W)
    ) u_slot (
      .clk      (clk),
      .act      (act),
      .eff_valid(eff_valid[l]),
      .in_pc    (in_pc[l*PC_W +: PC_W]),
      .in_inst  (in_inst[l*INST_W +: INST_W]),
      .valid    (out_valid[l]),
      .pc       (out_pc[l*PC_W +: PC_W]),
      .inst     (out_inst[l*INST_W +: INST_W])
    );
  end

  // stage boundary: bubble flag registered alongside the lane slots
  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET, ACT_FLUSH: out_bubble <= 1'b0;
      ACT_BUBBLE:           out_bubble <= 1'b1;
      ACT_CAPTURE:          out_bubble <= ~|eff_valid;
      default:              out_bubble <= out_bubble;
    endcase
  end

`ifdef PIPE_LANE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble_cnt <= '0;
      perf_hold_cnt   <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (act == ACT_BUBBLE) perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
      if (act == ACT_HOLD)   perf_hold_cnt   <= sat_inc(perf_hold_cnt);
      if (act == ACT_FLUSH)  perf_flush_cnt  <= sat_inc(perf_flush_cnt);
    end
  end
`endif

endmodule

// File: doc/pipe_lane_reg.md
Name: pipe_lane_reg

Overview:
- Parametrised inter-stage pipeline register; successor to the single-lane IF/ID latch.
- Carries NUM_LANES instruction slots (pc, inst, valid) from stage STAGE to stage STAGE+1.
- Driven by the global stall vector and flush from the pipeline controller.
- Adds per-lane kill (partial squash, e.g. younger lane behind a taken branch) and a bubble flag for downstream hazard logic.
- Instantiated at IF/ID and reusable at ID/EX for dual-issue builds.

Parameters:
- NUM_LANES, 1, instruction slots per stage (1..4).
- PC_W, 32, width of each pc field.
- INST_W, 32, width of each instruction field.
- STALL_W, 6, width of the global stall vector.
- STAGE, 1, index of the producing stage in the stall vector; legal range 0..STALL_W-2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  STALL_W  global stall vector; bit i = stage i stopped.
- flush  in  1  pipeline flush (exception/eret).
- in_valid  in  NUM_LANES  lane occupied in producing stage.
- in_kill  in  NUM_LANES  squash this lane on capture.
- in_pc  in  NUM_LANES*PC_W  lane pcs; lane 0 in the LSBs.
- in_inst  in  NUM_LANES*INST_W  lane instructions; lane 0 in the LSBs.
- out_valid  out  NUM_LANES  lane occupied in consuming stage.
- out_pc  out  NUM_LANES*PC_W  registered pcs.
- out_inst  out  NUM_LANES*INST_W  registered instructions.
- out_bubble  out  1  current contents are an inserted bubble.

Behaviour:
- All outputs are registers updated only on the rising clk edge; latency is 1 cycle.
- Define s_me = stall[STAGE] and s_nx = stall[STAGE+1].
- Priority is evaluated each edge, highest first:
  1. rst=1: out_valid=0, out_pc=0, out_inst=0 (nop), out_bubble=0.
  2. flush=1: all lanes cleared to valid=0, pc=0, inst=0; out_bubble=0. Flush overrides any stall.
  3. s_me=1 and s_nx=0: insert a bubble. All lanes cleared as in flush; out_bubble=1.
  4. s_me=0: capture. For each lane L, eff_valid[L] = in_valid[L] & ~in_kill[L].
     - eff_valid[L]=1: out_pc/out_inst of lane L take the inputs.
     - eff_valid[L]=0: lane L is zeroed (pc=0, inst=0, valid=0).
     - out_bubble=1 only when no lane has eff_valid set; otherwise 0.
  5. s_me=1 and s_nx=1: hold. All outputs keep their value, including out_bubble.
- in_kill on a lane with in_valid=0 has no effect.
- Kills are independent per lane. Killing a lower lane while a higher lane survives is legal; no compaction is performed.
- rst asserted mid-stall or mid-flush: reset wins that cycle. The first cycle after rst deasserts follows rules 2-5 normally.
- stall=0 for many cycles with constant inputs: the register re-captures every cycle; no sticky state.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PIPE_LANE_PERF_CNT_EN.
- When defined, adds three output ports, each 32 bits: perf_bubble_cnt, perf_hold_cnt, perf_flush_cnt.
  - Each counts the edges on which rule 3, 5 or 2 respectively applied.
  - Counters saturate at 32'hFFFFFFFF.
  - rst clears all three to 0.
- When undefined, the ports and the counter logic are absent. Core behaviour is identical with or without the macro.

Decomposition:
- Shared defines package holds:
  - ZeroWord, RstEnable, Stop/NoStop, InstAddrBus/InstBus widths.
  - Localparam encodings for the action decode: ACT_RESET, ACT_FLUSH, ACT_BUBBLE, ACT_CAPTURE, ACT_HOLD.
- One natural sub-module, pipe_lane_slot: a single lane's pc/inst/valid register. It takes the decoded action plus eff_valid and is instantiated NUM_LANES times by a generate loop.
- Action decode and perf counters live in the top.

Test Plan:
- NUM_LANES=1, STAGE=1: rst=1 for 2 cycles, then stall=0, in_pc=32'h00000004, in_inst=32'h34010001, in_valid=1 → next cycle out_pc=4, out_inst=32'h34010001, out_valid=1, out_bubble=0.
- stall=6'b000010 (stage1 stop, stage2 run) → out_valid=0, pc=0, inst=0, out_bubble=1.
- stall=6'b000110 → held prior contents for 3 cycles unchanged; perf_hold_cnt=3 with PIPE_LANE_PERF_CNT_EN.
- NUM_LANES=2: in_valid=2'b11, in_kill=2'b10, pcs 8/C → lane0 pc=8 valid; lane1 pc=0, inst=0, valid=0; out_bubble=0. in_kill=2'b11 → out_bubble=1.
- flush=1 together with stall=6'b000110 → all lanes cleared, out_bubble=0; perf_flush_cnt increments by 1.
- rst=1 asserted during a hold → all outputs 0 next edge; counters force-loaded to 32'hFFFFFFFE then two bubbles → reads 32'hFFFFFFFF (saturated).
